// File: rtl/tri_aoi21_pipe.sv
// tri_aoi21_pipe: pipelined AOI21/AO21/OAI21/OA21 lane array with valid/ready flow control.
// Bit 0 is the MSB on every operand and result vector.
module tri_aoi21_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_mode,
   input  logic [0:WIDTH-1]   a0,
   input  logic [0:WIDTH-1]   a1,
   input  logic [0:WIDTH-1]   b0,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [0:WIDTH-1]   y,
   output logic [1:0]         out_mode,
   output logic               busy
);
   logic [STAGES-1:0]              vld_q, vld_d, ld;
   logic [STAGES-1:0][0:WIDTH-1]   dat_q, dat_d;
   logic [STAGES-1:0][1:0]         mod_q, mod_d;
   logic [0:WIDTH-1]               f_w, res_w;
   logic                           acc_w;
   // mode[1] picks the OR-first form, mode[0]=0 selects the inverting variant
   assign f_w   = in_mode[1] ? ((a0 | a1) & b0) : ((a0 & a1) | b0);
   assign res_w = in_mode[0] ? f_w : ~f_w;
   // a stage can load unless it and every stage after it are full and the output is stalled
   for (genvar i = 0; i < STAGES; i++) begin : g_ld
      assign ld[i] = out_ready | ~(&vld_q[STAGES-1:i]);
   end
   assign in_ready = ~flush & ld[0];
   assign acc_w    = in_valid & in_ready;
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      mod_d = mod_q;
      if (ld[0]) begin
         vld_d[0] = acc_w;
         dat_d[0] = res_w;
         mod_d[0] = in_mode;
      end
      for (int s = 1; s < STAGES; s++) begin
         if (ld[s]) begin
            vld_d[s] = vld_q[s-1];
            dat_d[s] = dat_q[s-1];
            mod_d[s] = mod_q[s-1];
         end
      end
      if (flush) vld_d = '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         dat_q <= '0;
         mod_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
         mod_q <= mod_d;
      end
   end
   assign out_valid = vld_q[STAGES-1];
   assign y         = dat_q[STAGES-1];
   assign out_mode  = mod_q[STAGES-1];
   assign busy      = |vld_q;
endmodule

// File: doc/tri_aoi21_pipe.md
# tri_aoi21_pipe

Parametrised, pipelined AND-OR-INVERT datapath lane array with a run-time selectable gate function and a valid/ready handshake. Each beat carries WIDTH-bit operands a0, a1, b0 and a 2-bit function code. The result emerges after STAGES register stages. It sits between a producer and a consumer that both use valid/ready flow control, and replaces a bank of single-function combinational AOI21 cells wherever the result must be registered and back-pressure honoured.

## Interface
- WIDTH, 8: lanes per beat, 1..64; bit 0 is MSB ([0:WIDTH-1] ordering on all vectors).
- STAGES, 2: register stages from input to output, 1..4.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_mode  in  2  function code for this beat.
- a0  in  WIDTH  operand A0.
- a1  in  WIDTH  operand A1.
- b0  in  WIDTH  operand B0.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  result.
- out_mode  out  2  function code that produced y.
- busy  out  1  any stage holds a valid beat.

## Operation
- Function is per lane, per beat:
  - 00 AOI21: ~((a0&a1)|b0)
  - 01 AO21: (a0&a1)|b0
  - 10 OAI21: ~((a0|a1)&b0)
  - 11 OA21: (a0|a1)&b0
- Function is evaluated combinationally before stage 0. Stage 0 registers the result and mode, never the raw operands.
- Stages 1..STAGES-1 carry result, mode and valid unchanged.
- Stage i loads from its predecessor when it is empty or when it is advancing:
  - Stage STAGES-1 advances when out_valid & out_ready.
  - Stage i<STAGES-1 advances when stage i+1 loads.
- The ready chain is combinational, so bubbles collapse and a full pipeline with out_ready=1 sustains one beat per cycle.
- in_ready = ~flush & (stage 0 empty | stage 0 advancing).
- A beat is accepted iff in_valid & in_ready. When a stage loads nothing, its valid clears.
- Stage data registers may hold stale values while invalid. y and out_mode are meaningful only while out_valid=1.
- Stall rule: while out_valid=1 and out_ready=0, y and out_mode hold stable. No accepted beat is lost, duplicated or reordered.
- Flush:
  - All valid bits clear on the next edge.
  - in_ready is 0 during the flush cycle; a concurrent in_valid beat is dropped.
  - A concurrent out_valid & out_ready handshake still counts as delivered.
- busy = OR of all stage valid bits.

## Timing
- Reset (rst_n=0, asynchronous): all stage valids=0, all data and mode registers=0.
  - Hence out_valid=0, y=0, out_mode=00, busy=0.
  - in_ready=1 as soon as rst_n=1, provided flush=0.
- Reset deasserting mid-stream discards all in-flight beats; there is no partial state.
- Latency: a beat accepted at edge N appears on out_valid/y after edge N+STAGES-1 (visible in cycle N+STAGES-1 onward) when unstalled. With STAGES=1, the result is visible the cycle after acceptance.
- Throughput: 1 beat/cycle. Capacity: STAGES beats.
- Simultaneous accept into a full pipeline while the output drains: permitted, no bubble inserted.
- in_ready depends combinationally on out_ready. out_valid, y and out_mode are register outputs only.

## Test plan
- Function check: WIDTH=4, STAGES=2, a0=1100, a1=1010, b0=0001, out_ready=1. Mode 00 -> y=0110; 01 -> 1001; 10 -> 1111; 11 -> 0000. Each appears 1 cycle after acceptance, with out_mode matching.
- Streaming: 16 back-to-back beats with random modes, out_ready=1 -> 16 outputs on consecutive cycles, in order, equal to the reference model, in_ready stuck at 1.
- Back-pressure: fill with 3 beats while out_ready=0 (STAGES=2) -> in_ready falls after 2 accepts, y held stable. Raise out_ready -> both beats drain in order, then the third is accepted.
- Bubble collapse: beats on cycles 0 and 2, out_ready=0 until cycle 5 -> both beats resident, busy=1. On release they emit on consecutive cycles.
- Flush: 2 beats in flight plus in_valid=1 during flush -> next cycle out_valid=0, busy=0. The concurrent beat never appears at the output.
- Async reset: assert rst_n=0 mid-stall, off the clock edge -> out_valid, busy, y and out_mode go to 0 immediately. After release, the first new beat emerges with correct latency.
